mem_data_if: RTL and testbench

- Data-side access adapter between the CPU load/store unit and one port of the dual-port word memory (port B, data side).
- Converts byte/halfword/word requests with byte addresses into word address, byte-lane write enables and replicated write data.
- Extracts and sign/zero-extends read data, detects misaligned accesses, and enforces a bounded wait for memory ready.
- Memory byte ordering is big-endian (byte offset 0 = bits 31:24).

---
 rtl/mem_data_if_if.sv | 36 +++
 rtl/mem_data_if.sv | 165 ++++++++++++++++
 tb/tb_mem_data_if.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_data_if_if.sv
// Bundle for mem_data_if: CPU load/store request/response and data-side memory port B.
// master = the adapter, slave = the CPU/memory environment that drives it.
interface mem_data_if_if #(
    parameter int addr_size = 8
);
    logic                 cpu_req;
    logic [31:0]          cpu_addr;
    logic [31:0]          cpu_wdata;
    logic                 cpu_we;
    logic [1:0]           cpu_size;
    logic                 cpu_signed;
    logic [31:0]          cpu_rdata;
    logic                 cpu_ack;
    logic                 cpu_error;
    logic                 cpu_busy;
    logic [addr_size-1:0] mem_addr;
    logic [31:0]          mem_din;
    logic [3:0]           mem_wr;
    logic                 mem_enable;
    logic [31:0]          mem_dout;
    logic                 mem_ready;

    modport master (
        input  cpu_req, cpu_addr, cpu_wdata, cpu_we, cpu_size, cpu_signed,
        input  mem_dout, mem_ready,
        output cpu_rdata, cpu_ack, cpu_error, cpu_busy,
        output mem_addr, mem_din, mem_wr, mem_enable
    );

    modport slave (
        output cpu_req, cpu_addr, cpu_wdata, cpu_we, cpu_size, cpu_signed,
        output mem_dout, mem_ready,
        input  cpu_rdata, cpu_ack, cpu_error, cpu_busy,
        input  mem_addr, mem_din, mem_wr, mem_enable
    );
endinterface

// File: rtl/mem_data_if.sv
// Data-side adapter: byte/half/word CPU accesses onto a big-endian word memory port,
// with misalignment rejection and a bounded wait for mem_ready.
//
//   state | meaning
//   IDLE  | waiting for cpu_req, request fields latched on acceptance
//   ISSUE | mem_enable high for one cycle with address, lanes and data
//   WAIT  | waiting for mem_ready, timeout counter running
//   RESP  | cpu_ack (and cpu_error if any) high for one cycle
module mem_data_if #(
    parameter int addr_size = 8,
    parameter int timeout   = 4
) (
    input logic          clk,
    input logic          rst,
    mem_data_if_if.master bus
);
    localparam int CW = $clog2(timeout + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               r_state;
    logic                 r_we;
    logic                 r_signed;
    logic [1:0]           r_size;
    logic [1:0]           r_off;
    logic [CW-1:0]        r_cnt;
    logic [31:0]          r_cpu_rdata;
    logic                 r_cpu_ack;
    logic                 r_cpu_error;
    logic                 r_cpu_busy;
    logic                 r_mem_enable;
    logic [3:0]           r_mem_wr;
    logic [addr_size-1:0] r_mem_addr;
    logic [31:0]          r_mem_din;

    logic                 w_misaligned;
    logic [3:0]           w_lanes;
    logic [31:0]          w_din;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [31:0]          w_rdata;
    logic                 w_unused_addr;

    assign w_unused_addr = ^bus.cpu_addr[31:addr_size+2];

    always_comb begin
        w_misaligned = 1'b0;
        w_lanes      = 4'b0000;
        w_din        = bus.cpu_wdata;
        case (bus.cpu_size)
            2'b00: begin
                w_lanes = 4'b1000 >> bus.cpu_addr[1:0];
                w_din   = {4{bus.cpu_wdata[7:0]}};
            end
            2'b01: begin
                w_misaligned = bus.cpu_addr[0];
                w_lanes      = bus.cpu_addr[1] ? 4'b0011 : 4'b1100;
                w_din        = {2{bus.cpu_wdata[15:0]}};
            end
            2'b10: begin
                w_misaligned = |bus.cpu_addr[1:0];
                w_lanes      = 4'b1111;
            end
            default: w_misaligned = 1'b1;
        endcase
        if (!bus.cpu_we) w_lanes = 4'b0000;
    end

    // Big-endian: byte offset 0 sits in the top lane.
    always_comb begin
        w_byte = 8'h00;
        case (r_off)
            2'd0: w_byte = bus.mem_dout[31:24];
            2'd1: w_byte = bus.mem_dout[23:16];
            2'd2: w_byte = bus.mem_dout[15:8];
            default: w_byte = bus.mem_dout[7:0];
        endcase
        w_half  = r_off[1] ? bus.mem_dout[15:0] : bus.mem_dout[31:16];
        w_rdata = bus.mem_dout;
        case (r_size)
            2'b00:   w_rdata = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b01:   w_rdata = {{16{r_signed & w_half[15]}}, w_half};
            default: w_rdata = bus.mem_dout;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_signed     <= 1'b0;
            r_size       <= 2'b00;
            r_off        <= 2'b00;
            r_cnt        <= '0;
            r_cpu_rdata  <= 32'h0;
            r_cpu_ack    <= 1'b0;
            r_cpu_error  <= 1'b0;
            r_cpu_busy   <= 1'b0;
            r_mem_enable <= 1'b0;
            r_mem_wr     <= 4'b0000;
            r_mem_addr   <= '0;
            r_mem_din    <= 32'h0;
        end else begin
            r_cpu_ack   <= 1'b0;
            r_cpu_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.cpu_req) begin
                        r_we       <= bus.cpu_we;
                        r_signed   <= bus.cpu_signed;
                        r_size     <= bus.cpu_size;
                        r_off      <= bus.cpu_addr[1:0];
                        r_cpu_busy <= 1'b1;
                        if (w_misaligned) begin
                            r_state     <= RESP;
                            r_cpu_ack   <= 1'b1;
                            r_cpu_error <= 1'b1;
                            r_cpu_rdata <= 32'h0;
                        end else begin
                            r_state      <= ISSUE;
                            r_mem_enable <= 1'b1;
                            r_mem_addr   <= bus.cpu_addr[addr_size+1:2];
                            r_mem_din    <= w_din;
                            r_mem_wr     <= w_lanes;
                        end
                    end
                end
                ISSUE: begin
                    r_mem_enable <= 1'b0;
                    r_mem_wr     <= 4'b0000;
                    r_cnt        <= '0;
                    r_state      <= WAIT;
                end
                WAIT: begin
                    if (bus.mem_ready) begin
                        r_state     <= RESP;
                        r_cpu_ack   <= 1'b1;
                        r_cpu_rdata <= r_we ? 32'h0 : w_rdata;
                    end else if (r_cnt == CW'(timeout - 1)) begin
                        r_state     <= RESP;
                        r_cpu_ack   <= 1'b1;
                        r_cpu_error <= 1'b1;
                        r_cpu_rdata <= 32'h0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    r_state    <= IDLE;
                    r_cpu_busy <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cpu_rdata  = r_cpu_rdata;
    assign bus.cpu_ack    = r_cpu_ack;
    assign bus.cpu_error  = r_cpu_error;
    assign bus.cpu_busy   = r_cpu_busy;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_din    = r_mem_din;
    assign bus.mem_wr     = r_mem_wr;
    assign bus.mem_enable = r_mem_enable;
endmodule

// File: tb/tb_mem_data_if.sv
// Bench for mem_data_if: behavioural word memory plus scoreboards for memory
// operations and CPU acknowledges (data, error flag, latency).
module tb_mem_data_if;
    localparam int ASZ = 8;
    localparam int TMO = 4;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          delta;
    } ack_exp_t;

    typedef struct {
        logic [7:0]  addr;
        logic [3:0]  wr;
        logic [31:0] din;
        logic        we;
    } mem_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   req_cyc = 0;
    int   ack_cnt = 0;
    bit   respond = 1'b1;
    bit   pend = 1'b0;
    logic [31:0] rd_val;
    logic [31:0] mem [256];

    ack_exp_t q_ack[$];
    mem_exp_t q_mem[$];

    mem_data_if_if #(.addr_size(ASZ)) bus ();

    mem_data_if #(.addr_size(ASZ), .timeout(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One-cycle memory: enable seen after edge E, ready/data valid after edge E+1.
    always @(posedge clk) begin
        #1;
        bus.mem_ready = 1'b0;
        if (pend) begin
            bus.mem_ready = 1'b1;
            bus.mem_dout  = rd_val;
            pend = 1'b0;
        end
        if (bus.mem_enable && respond) begin
            pend   = 1'b1;
            rd_val = mem[bus.mem_addr];
            if (bus.mem_wr[3]) mem[bus.mem_addr][31:24] = bus.mem_din[31:24];
            if (bus.mem_wr[2]) mem[bus.mem_addr][23:16] = bus.mem_din[23:16];
            if (bus.mem_wr[1]) mem[bus.mem_addr][15:8]  = bus.mem_din[15:8];
            if (bus.mem_wr[0]) mem[bus.mem_addr][7:0]   = bus.mem_din[7:0];
        end
    end

    always @(negedge clk) begin
        if (bus.mem_enable) begin
            if (q_mem.size() == 0) begin
                check("unexpected_mem_enable", 32'd1, 32'd0);
            end else begin
                mem_exp_t m;
                m = q_mem.pop_front();
                check("mem_addr", 32'(bus.mem_addr), 32'(m.addr));
                check("mem_wr", 32'(bus.mem_wr), 32'(m.wr));
                if (m.we) check("mem_din", bus.mem_din, m.din);
            end
        end
    end

    always @(negedge clk) begin
        if (bus.cpu_ack) begin
            ack_cnt++;
            if (q_ack.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                ack_exp_t a;
                a = q_ack.pop_front();
                check("cpu_rdata", bus.cpu_rdata, a.rd);
                check("cpu_error", 32'(bus.cpu_error), 32'(a.err));
                check("ack_latency", 32'(cyc - req_cyc), 32'(a.delta));
                check("busy_at_ack", 32'(bus.cpu_busy), 32'd1);
            end
        end
    end

    task automatic drive_req(input logic we, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic sgn);
        @(negedge clk);
        bus.cpu_we     = we;
        bus.cpu_size   = size;
        bus.cpu_addr   = addr;
        bus.cpu_wdata  = wdata;
        bus.cpu_signed = sgn;
        bus.cpu_req    = 1'b1;
        req_cyc        = cyc + 1;
        @(posedge clk);
        #1 bus.cpu_req = 1'b0;
    endtask

    task automatic access(input logic we, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic sgn,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_delta,
                          input logic mem_op, input logic [3:0] exp_wr, input logic [31:0] exp_din);
        ack_exp_t a;
        mem_exp_t m;
        int start;
        bit seen;
        a.rd = exp_rd; a.err = exp_err; a.delta = exp_delta;
        q_ack.push_back(a);
        if (mem_op) begin
            m.addr = addr[9:2]; m.wr = exp_wr; m.din = exp_din; m.we = we;
            q_mem.push_back(m);
        end
        start = ack_cnt;
        seen  = 1'b0;
        drive_req(we, size, addr, wdata, sgn);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (ack_cnt != start) seen = 1'b1;
        end
        if (!seen) check("ack_wait_expired", 32'd0, 32'd1);
        @(negedge clk);
        check("ack_one_cycle", 32'(bus.cpu_ack), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdata"}, bus.cpu_rdata, 32'h0);
        check({tag, "_ack"}, 32'(bus.cpu_ack), 32'h0);
        check({tag, "_error"}, 32'(bus.cpu_error), 32'h0);
        check({tag, "_busy"}, 32'(bus.cpu_busy), 32'h0);
        check({tag, "_mem_enable"}, 32'(bus.mem_enable), 32'h0);
        check({tag, "_mem_wr"}, 32'(bus.mem_wr), 32'h0);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'h0);
        check({tag, "_mem_din"}, bus.mem_din, 32'h0);
    endtask

    initial begin
        mem_exp_t m;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        bus.cpu_req = 1'b0; bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;
        bus.cpu_we = 1'b0; bus.cpu_size = 2'b00; bus.cpu_signed = 1'b0;
        bus.mem_dout = 32'h0; bus.mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Word store then load
        access(1, 2'b10, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0, 2, 1, 4'b1111, 32'hDEADBEEF);
        access(0, 2'b10, 32'h10, 32'h0, 0, 32'hDEADBEEF, 0, 2, 1, 4'b0000, 32'h0);
        // Byte store at offset 3, then signed/unsigned byte loads
        access(1, 2'b00, 32'h13, 32'h80, 0, 32'h0, 0, 2, 1, 4'b0001, 32'h80808080);
        access(0, 2'b00, 32'h13, 32'h0, 1, 32'hFFFFFF80, 0, 2, 1, 4'b0000, 32'h0);
        access(0, 2'b00, 32'h13, 32'h0, 0, 32'h00000080, 0, 2, 1, 4'b0000, 32'h0);
        access(0, 2'b00, 32'h10, 32'h0, 1, 32'hFFFFFFDE, 0, 2, 1, 4'b0000, 32'h0);
        access(0, 2'b01, 32'h12, 32'h0, 1, 32'hFFFFBE80, 0, 2, 1, 4'b0000, 32'h0);
        // Halfword store at offset 2 and lane checks
        access(1, 2'b01, 32'h22, 32'h1234, 0, 32'h0, 0, 2, 1, 4'b0011, 32'h12341234);
        access(0, 2'b01, 32'h22, 32'h0, 1, 32'h00001234, 0, 2, 1, 4'b0000, 32'h0);
        access(1, 2'b00, 32'h31, 32'hA5, 0, 32'h0, 0, 2, 1, 4'b0100, 32'hA5A5A5A5);
        access(1, 2'b01, 32'h30, 32'h5A5A, 0, 32'h0, 0, 2, 1, 4'b1100, 32'h5A5A5A5A);
        access(0, 2'b10, 32'h30, 32'h0, 0, 32'h5A5A0000, 0, 2, 1, 4'b0000, 32'h0);
        access(1, 2'b10, 32'h20, 32'h80001234, 0, 32'h0, 0, 2, 1, 4'b1111, 32'h80001234);
        access(0, 2'b01, 32'h20, 32'h0, 1, 32'hFFFF8000, 0, 2, 1, 4'b0000, 32'h0);
        access(0, 2'b01, 32'h20, 32'h0, 0, 32'h00008000, 0, 2, 1, 4'b0000, 32'h0);
        // Misaligned / invalid: immediate error ack, no memory access
        access(0, 2'b10, 32'h11, 32'h0, 0, 32'h0, 1, 0, 0, 4'b0000, 32'h0);
        access(0, 2'b01, 32'h03, 32'h0, 0, 32'h0, 1, 0, 0, 4'b0000, 32'h0);
        access(0, 2'b11, 32'h00, 32'h0, 0, 32'h0, 1, 0, 0, 4'b0000, 32'h0);

        // Timeout with an ignored request while busy, then repeat for same latency
        respond = 1'b0;
        fork
            access(0, 2'b10, 32'h10, 32'h0, 0, 32'h0, 1, TMO + 1, 1, 4'b0000, 32'h0);
            begin
                repeat (3) @(negedge clk);
                bus.cpu_req = 1'b1; bus.cpu_addr = 32'h20; bus.cpu_size = 2'b10; bus.cpu_we = 1'b0;
                @(negedge clk);
                bus.cpu_req = 1'b0;
            end
        join
        access(1, 2'b10, 32'h40, 32'h11223344, 0, 32'h0, 1, TMO + 1, 1, 4'b1111, 32'h11223344);

        // Reset while in WAIT: no ack, all outputs cleared, then normal access
        m.addr = 8'h04; m.wr = 4'b0000; m.din = 32'h0; m.we = 1'b0;
        q_mem.push_back(m);
        drive_req(0, 2'b10, 32'h10, 32'h0, 0);
        @(negedge clk);
        check("busy_in_wait", 32'(bus.cpu_busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        rst = 1'b0;
        repeat (8) @(negedge clk);
        respond = 1'b1;
        access(0, 2'b10, 32'h10, 32'h0, 0, 32'hDEADBE80, 0, 2, 1, 4'b0000, 32'h0);

        repeat (4) @(negedge clk);
        check("ack_queue_drained", 32'(q_ack.size()), 32'd0);
        check("mem_queue_drained", 32'(q_mem.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: got expired expected finished");
        $fatal(1);
    end
endmodule
